// File: rtl/mc_sync_queue.sv
// ---------------------------------------------------------------------------
// mc_sync_queue
//
// Single-clock multi-channel FIFO. C independent logical queues of N entries
// of W bits share one storage array, one push port and one pop port. Each
// channel keeps its own read/write pointers and occupancy counter, and all
// status flags are registered from the next-state values. As a result, every
// flag reflects the state after the current edge, and no input reaches an
// output combinationally.
//
// Ports
//   clk            clock, all logic on posedge
//   rst            synchronous active-low reset
//   push           write request
//   push_chan      target channel of push
//   push_data      write data
//   pop            read request
//   pop_chan       source channel of pop
//   pop_data       read data (holds last value when pop_data_vld_r = 0)
//   pop_data_vld_r read data valid, one cycle after an accepted pop
//   pop_chan_r     channel that produced pop_data
//   flush          per-channel flush request (multi-hot allowed)
//   clear_err      clears all sticky error bits
//   empty_r        per-channel empty
//   full_r         per-channel full
//   almost_full_r  per-channel occupancy >= AF_THRESH
//   occ_r          per-channel occupancy, channel k at [k*L +: L]
//   ovf_err_r      sticky: push attempted to a full channel
//   unf_err_r      sticky: pop attempted from an empty channel
// ---------------------------------------------------------------------------
module mc_sync_queue #(
    parameter int W         = 32,
    parameter int N         = 16,
    parameter int C         = 4,
    parameter int AF_THRESH = 12
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             push,
    input  logic [$clog2(C)-1:0]             push_chan,
    input  logic [W-1:0]                     push_data,
    input  logic                             pop,
    input  logic [$clog2(C)-1:0]             pop_chan,
    output logic [W-1:0]                     pop_data,
    output logic                             pop_data_vld_r,
    output logic [$clog2(C)-1:0]             pop_chan_r,
    input  logic [C-1:0]                     flush,
    input  logic                             clear_err,
    output logic [C-1:0]                     empty_r,
    output logic [C-1:0]                     full_r,
    output logic [C-1:0]                     almost_full_r,
    output logic [C*($clog2(N)+1)-1:0]       occ_r,
    output logic [C-1:0]                     ovf_err_r,
    output logic [C-1:0]                     unf_err_r
);

    localparam int AW = $clog2(N);   // address bits inside one channel
    localparam int L  = AW + 1;      // pointer / occupancy width (MSB = wrap)
    localparam int CW = $clog2(C);   // channel index width

    // Shared storage: channel k occupies words [k*N .. k*N+N-1].
    logic [W-1:0]             mem [C*N];

    // Low pointer bits of every channel, gathered so the shared ports can
    // select the active channel's slot.
    logic [C-1:0][AW-1:0]     waddr_all;
    logic [C-1:0][AW-1:0]     raddr_all;

    // Per-channel acceptance, OR-reduced to drive the shared storage ports.
    logic [C-1:0]             push_ok_vec;
    logic [C-1:0]             pop_ok_vec;
    logic                     push_acc;
    logic                     pop_acc;

    logic [CW+AW-1:0]         wr_addr;
    logic [CW+AW-1:0]         rd_addr;

    logic [W-1:0]             pop_data_reg;
    logic                     pop_vld_reg;
    logic [CW-1:0]            pop_chan_reg;

    assign push_acc = |push_ok_vec;
    assign pop_acc  = |pop_ok_vec;
    assign wr_addr  = {push_chan, waddr_all[push_chan]};
    assign rd_addr  = {pop_chan,  raddr_all[pop_chan]};

    // -----------------------------------------------------------------------
    // Per-channel control: pointers, occupancy, status flags, sticky errors.
    // -----------------------------------------------------------------------
    genvar gi;
    for (gi = 0; gi < C; gi++) begin : g_chan
        logic [L-1:0] wptr_reg, wptr_next;
        logic [L-1:0] rptr_reg, rptr_next;
        logic [L-1:0] occ_reg,  occ_next;
        logic         empty_reg, empty_next;
        logic         full_reg,  full_next;
        logic         af_reg,    af_next;
        logic         ovf_reg,   ovf_next;
        logic         unf_reg,   unf_next;
        logic         push_hit, pop_hit;
        logic         push_ok,  pop_ok;
        logic         ovf_set,  unf_set;

        assign push_hit = push && (push_chan == CW'(gi));
        assign pop_hit  = pop  && (pop_chan  == CW'(gi));

        // Requests are judged against the registered flags of this cycle,
        // so a same-cycle push+pop at full drops the push, and at empty
        // underflows the pop (no bypass). Flush swallows both without error.
        assign push_ok = push_hit && !full_reg  && !flush[gi];
        assign pop_ok  = pop_hit  && !empty_reg && !flush[gi];
        assign ovf_set = push_hit &&  full_reg  && !flush[gi];
        assign unf_set = pop_hit  &&  empty_reg && !flush[gi];

        assign push_ok_vec[gi] = push_ok;
        assign pop_ok_vec[gi]  = pop_ok;
        assign waddr_all[gi]   = wptr_reg[AW-1:0];
        assign raddr_all[gi]   = rptr_reg[AW-1:0];

        always_comb begin
            wptr_next = wptr_reg;
            rptr_next = rptr_reg;
            occ_next  = occ_reg;
            if (flush[gi]) begin
                wptr_next = '0;
                rptr_next = '0;
                occ_next  = '0;
            end else begin
                if (push_ok) begin
                    wptr_next = wptr_reg + L'(1);
                end
                if (pop_ok) begin
                    rptr_next = rptr_reg + L'(1);
                end
                case ({push_ok, pop_ok})
                    2'b10:   occ_next = occ_reg + L'(1);
                    2'b01:   occ_next = occ_reg - L'(1);
                    default: occ_next = occ_reg;
                endcase
            end
        end

        // Flags are derived from next-state pointers so they line up with
        // the pointer registers after the edge.
        assign empty_next = (wptr_next == rptr_next);
        assign full_next  = (wptr_next[AW] != rptr_next[AW]) &&
                            (wptr_next[AW-1:0] == rptr_next[AW-1:0]);
        assign af_next    = (occ_next >= L'(AF_THRESH));

        // clear_err wins over a same-cycle set.
        assign ovf_next = clear_err ? 1'b0 : (ovf_reg | ovf_set);
        assign unf_next = clear_err ? 1'b0 : (unf_reg | unf_set);

        always_ff @(posedge clk) begin
            if (!rst) begin
                wptr_reg  <= '0;
                rptr_reg  <= '0;
                occ_reg   <= '0;
                empty_reg <= 1'b1;
                full_reg  <= 1'b0;
                af_reg    <= 1'b0;
                ovf_reg   <= 1'b0;
                unf_reg   <= 1'b0;
            end else begin
                wptr_reg  <= wptr_next;
                rptr_reg  <= rptr_next;
                occ_reg   <= occ_next;
                empty_reg <= empty_next;
                full_reg  <= full_next;
                af_reg    <= af_next;
                ovf_reg   <= ovf_next;
                unf_reg   <= unf_next;
            end
        end

        assign empty_r[gi]        = empty_reg;
        assign full_r[gi]         = full_reg;
        assign almost_full_r[gi]  = af_reg;
        assign ovf_err_r[gi]      = ovf_reg;
        assign unf_err_r[gi]      = unf_reg;
        assign occ_r[gi*L +: L]   = occ_reg;
    end

    // -----------------------------------------------------------------------
    // Shared storage. Contents are deliberately not reset.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (push_acc) begin
            mem[wr_addr] <= push_data;
        end
    end

    // Registered read port. Same-channel push/pop never target the same
    // word in one cycle (at empty the pop is rejected, at full the push is),
    // so no read-during-write handling is needed.
    always_ff @(posedge clk) begin
        if (!rst) begin
            pop_data_reg <= '0;
            pop_vld_reg  <= 1'b0;
            pop_chan_reg <= '0;
        end else begin
            pop_vld_reg <= pop_acc;
            if (pop_acc) begin
                pop_data_reg <= mem[rd_addr];
                pop_chan_reg <= pop_chan;
            end
        end
    end

    assign pop_data       = pop_data_reg;
    assign pop_data_vld_r = pop_vld_reg;
    assign pop_chan_r     = pop_chan_reg;

endmodule

// File: tb/tb_mc_sync_queue.sv
module tb_mc_sync_queue;

    localparam int W = 32;
    localparam int N = 16;
    localparam int C = 4;
    localparam int AF_THRESH = 12;
    localparam int L = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          push;
    logic [1:0]    push_chan;
    logic [W-1:0]  push_data;
    logic          pop;
    logic [1:0]    pop_chan;
    logic [W-1:0]  pop_data;
    logic          pop_data_vld_r;
    logic [1:0]    pop_chan_r;
    logic [C-1:0]  flush;
    logic          clear_err;
    logic [C-1:0]  empty_r;
    logic [C-1:0]  full_r;
    logic [C-1:0]  almost_full_r;
    logic [C*L-1:0] occ_r;
    logic [C-1:0]  ovf_err_r;
    logic [C-1:0]  unf_err_r;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    mc_sync_queue #(.W(W), .N(N), .C(C), .AF_THRESH(AF_THRESH)) dut (
        .clk(clk), .rst(rst),
        .push(push), .push_chan(push_chan), .push_data(push_data),
        .pop(pop), .pop_chan(pop_chan),
        .pop_data(pop_data), .pop_data_vld_r(pop_data_vld_r), .pop_chan_r(pop_chan_r),
        .flush(flush), .clear_err(clear_err),
        .empty_r(empty_r), .full_r(full_r), .almost_full_r(almost_full_r),
        .occ_r(occ_r), .ovf_err_r(ovf_err_r), .unf_err_r(unf_err_r)
    );

    typedef struct {
        logic        push;
        logic [1:0]  pch;
        logic [31:0] pdata;
        logic        pop;
        logic [1:0]  qch;
        logic [3:0]  fl;
        logic        clr;
        logic        vld;
        logic [31:0] data;
        logic [1:0]  ch;
        logic [3:0]  emp;
        logic [3:0]  full;
        logic [3:0]  af;
        logic [19:0] occ;
        logic [3:0]  ovf;
        logic [3:0]  unf;
    } vec_t;

    vec_t vecs [16];

    function automatic logic [19:0] occ4(input int a, input int b, input int c, input int d);
        logic [4:0] oa, ob, oc, od;
        oa = 5'(a); ob = 5'(b); oc = 5'(c); od = 5'(d);
        return {od, oc, ob, oa};
    endfunction

    function automatic vec_t mk(
        input logic ps, input logic [1:0] pc, input logic [31:0] pd,
        input logic pp, input logic [1:0] qc, input logic [3:0] fl, input logic clr,
        input logic vld, input logic [31:0] data, input logic [1:0] ch,
        input logic [3:0] emp, input logic [3:0] full, input logic [3:0] af,
        input logic [19:0] occ, input logic [3:0] ovf, input logic [3:0] unf);
        vec_t v;
        v.push = ps; v.pch = pc; v.pdata = pd; v.pop = pp; v.qch = qc;
        v.fl = fl; v.clr = clr; v.vld = vld; v.data = data; v.ch = ch;
        v.emp = emp; v.full = full; v.af = af; v.occ = occ; v.ovf = ovf; v.unf = unf;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp)
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else
            n_pass++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        push = 1'b0; push_chan = 2'd0; push_data = '0;
        pop = 1'b0; pop_chan = 2'd0; flush = '0; clear_err = 1'b0;
    endtask

    task automatic do_push(input logic [1:0] ch, input logic [31:0] d);
        idle();
        push = 1'b1; push_chan = ch; push_data = d;
        step();
    endtask

    task automatic do_pop(input logic [1:0] ch);
        idle();
        pop = 1'b1; pop_chan = ch;
        step();
    endtask

    function automatic logic [4:0] occ_of(input int k);
        return occ_r[k*L +: L];
    endfunction

    logic [31:0] q0[$];
    logic [31:0] q1[$];

    initial begin
        rst = 1'b0;
        idle();
        repeat (3) step();

        // Reset state
        check("rst.vld",   64'(pop_data_vld_r), 64'd0);
        check("rst.data",  64'(pop_data), 64'd0);
        check("rst.chan",  64'(pop_chan_r), 64'd0);
        check("rst.empty", 64'(empty_r), 64'hF);
        check("rst.full",  64'(full_r), 64'd0);
        check("rst.af",    64'(almost_full_r), 64'd0);
        check("rst.occ",   64'(occ_r), 64'd0);
        check("rst.err",   64'({ovf_err_r, unf_err_r}), 64'd0);
        $display("reset state checked");
        rst = 1'b1;
        step();

        // Table: ch1 FIFO order, underflow, clear priority, empty same-cycle, flush
        //               push pch pdata     pop qch fl    clr vld data      ch emp    full af  occ             ovf    unf
        vecs[0]  = mk(1, 1, 32'hA0, 0, 0, 4'h0, 0, 0, 32'h0,  0, 4'b1101, 0, 0, occ4(0,1,0,0), 4'h0, 4'h0);
        vecs[1]  = mk(1, 1, 32'hA1, 0, 0, 4'h0, 0, 0, 32'h0,  0, 4'b1101, 0, 0, occ4(0,2,0,0), 4'h0, 4'h0);
        vecs[2]  = mk(1, 1, 32'hA2, 0, 0, 4'h0, 0, 0, 32'h0,  0, 4'b1101, 0, 0, occ4(0,3,0,0), 4'h0, 4'h0);
        vecs[3]  = mk(1, 1, 32'hA3, 0, 0, 4'h0, 0, 0, 32'h0,  0, 4'b1101, 0, 0, occ4(0,4,0,0), 4'h0, 4'h0);
        vecs[4]  = mk(0, 0, 32'h0,  1, 1, 4'h0, 0, 1, 32'hA0, 1, 4'b1101, 0, 0, occ4(0,3,0,0), 4'h0, 4'h0);
        vecs[5]  = mk(0, 0, 32'h0,  1, 1, 4'h0, 0, 1, 32'hA1, 1, 4'b1101, 0, 0, occ4(0,2,0,0), 4'h0, 4'h0);
        vecs[6]  = mk(0, 0, 32'h0,  1, 1, 4'h0, 0, 1, 32'hA2, 1, 4'b1101, 0, 0, occ4(0,1,0,0), 4'h0, 4'h0);
        vecs[7]  = mk(0, 0, 32'h0,  1, 1, 4'h0, 0, 1, 32'hA3, 1, 4'b1111, 0, 0, occ4(0,0,0,0), 4'h0, 4'h0);
        vecs[8]  = mk(0, 0, 32'h0,  0, 0, 4'h0, 0, 0, 32'hA3, 1, 4'b1111, 0, 0, occ4(0,0,0,0), 4'h0, 4'h0);
        vecs[9]  = mk(0, 0, 32'h0,  1, 0, 4'h0, 0, 0, 32'hA3, 1, 4'b1111, 0, 0, occ4(0,0,0,0), 4'h0, 4'h1);
        vecs[10] = mk(0, 0, 32'h0,  0, 0, 4'h0, 1, 0, 32'hA3, 1, 4'b1111, 0, 0, occ4(0,0,0,0), 4'h0, 4'h0);
        vecs[11] = mk(0, 0, 32'h0,  1, 0, 4'h0, 1, 0, 32'hA3, 1, 4'b1111, 0, 0, occ4(0,0,0,0), 4'h0, 4'h0);
        vecs[12] = mk(1, 3, 32'h77, 1, 3, 4'h0, 0, 0, 32'hA3, 1, 4'b0111, 0, 0, occ4(0,0,0,1), 4'h0, 4'h8);
        vecs[13] = mk(0, 0, 32'h0,  1, 3, 4'h0, 0, 1, 32'h77, 3, 4'b1111, 0, 0, occ4(0,0,0,0), 4'h0, 4'h8);
        vecs[14] = mk(0, 0, 32'h0,  0, 0, 4'h0, 1, 0, 32'h77, 3, 4'b1111, 0, 0, occ4(0,0,0,0), 4'h0, 4'h0);
        vecs[15] = mk(1, 0, 32'h11, 1, 0, 4'h1, 0, 0, 32'h77, 3, 4'b1111, 0, 0, occ4(0,0,0,0), 4'h0, 4'h0);

        for (int i = 0; i < 16; i++) begin
            push = vecs[i].push; push_chan = vecs[i].pch; push_data = vecs[i].pdata;
            pop = vecs[i].pop; pop_chan = vecs[i].qch; flush = vecs[i].fl;
            clear_err = vecs[i].clr;
            step();
            check($sformatf("v%0d.vld", i),   64'(pop_data_vld_r), 64'(vecs[i].vld));
            check($sformatf("v%0d.data", i),  64'(pop_data), 64'(vecs[i].data));
            check($sformatf("v%0d.chan", i),  64'(pop_chan_r), 64'(vecs[i].ch));
            check($sformatf("v%0d.empty", i), 64'(empty_r), 64'(vecs[i].emp));
            check($sformatf("v%0d.full", i),  64'(full_r), 64'(vecs[i].full));
            check($sformatf("v%0d.af", i),    64'(almost_full_r), 64'(vecs[i].af));
            check($sformatf("v%0d.occ", i),   64'(occ_r), 64'(vecs[i].occ));
            check($sformatf("v%0d.ovf", i),   64'(ovf_err_r), 64'(vecs[i].ovf));
            check($sformatf("v%0d.unf", i),   64'(unf_err_r), 64'(vecs[i].unf));
            $display("vec %0d: vld=%0b data=%0h chan=%0d occ=%0h empty=%b", i,
                     pop_data_vld_r, pop_data, pop_chan_r, occ_r, empty_r);
        end
        idle();

        // Fill ch2 to full, then overflow
        for (int i = 0; i < 16; i++) begin
            do_push(2'd2, 32'h200 + 32'(i));
            check($sformatf("fill%0d.occ2", i), 64'(occ_of(2)), 64'(i + 1));
            check($sformatf("fill%0d.af2", i),  64'(almost_full_r[2]), 64'((i + 1) >= 12));
            check($sformatf("fill%0d.full2", i), 64'(full_r[2]), 64'(i == 15));
            $display("fill ch2 push %0d: occ2=%0d af=%b full=%b", i, occ_of(2), almost_full_r, full_r);
        end
        do_push(2'd2, 32'hDEAD);
        check("ovf.full2", 64'(full_r[2]), 64'd1);
        check("ovf.err",   64'(ovf_err_r), 64'h4);
        check("ovf.occ2",  64'(occ_of(2)), 64'd16);
        check("ovf.empty", 64'(empty_r), 64'b1011);
        $display("ch2 overflow push: ovf=%b occ2=%0d", ovf_err_r, occ_of(2));
        idle(); flush = 4'b0100; clear_err = 1'b1; step(); idle();
        check("fl2.empty", 64'(empty_r), 64'hF);
        check("fl2.ovf",   64'(ovf_err_r), 64'h0);
        $display("ch2 flushed: empty=%b", empty_r);

        // ch3 full: same-cycle push+pop -> pop wins, push dropped
        for (int i = 0; i < 16; i++) do_push(2'd3, 32'h300 + 32'(i));
        idle(); push = 1'b1; push_chan = 2'd3; push_data = 32'h55; pop = 1'b1; pop_chan = 2'd3;
        step(); idle();
        check("f3.vld",  64'(pop_data_vld_r), 64'd1);
        check("f3.data", 64'(pop_data), 64'h300);
        check("f3.chan", 64'(pop_chan_r), 64'd3);
        check("f3.ovf",  64'(ovf_err_r), 64'h8);
        check("f3.occ3", 64'(occ_of(3)), 64'd15);
        check("f3.full", 64'(full_r[3]), 64'd0);
        $display("ch3 full push+pop: data=%0h ovf=%b occ3=%0d", pop_data, ovf_err_r, occ_of(3));
        for (int i = 1; i < 16; i++) begin
            do_pop(2'd3);
            check($sformatf("drain3_%0d", i), 64'(pop_data), 64'h300 + 64'(i));
            $display("drain ch3: data=%0h", pop_data);
        end
        idle(); clear_err = 1'b1; step(); idle();
        check("drain3.empty", 64'(empty_r), 64'hF);
        check("drain3.err",   64'({ovf_err_r, unf_err_r}), 64'd0);

        // Interleave ch0/ch1 with pointer wrap
        for (int i = 0; i < 40; i++) begin
            logic [1:0]  pc;
            logic        dp;
            logic [31:0] expd;
            logic [31:0] d;
            d = 32'hC000_0000 | 32'(i);
            pc = (i % 2 == 1) ? 2'd0 : 2'd1;
            dp = (pc == 2'd0) ? (q0.size() > 0) : (q1.size() > 0);
            expd = '0;
            if (dp) expd = (pc == 2'd0) ? q0.pop_front() : q1.pop_front();
            idle();
            push = 1'b1; push_chan = 2'(i % 2); push_data = d;
            pop = dp; pop_chan = pc;
            step();
            if (i % 2 == 0) q0.push_back(d); else q1.push_back(d);
            check($sformatf("il%0d.vld", i), 64'(pop_data_vld_r), 64'(dp));
            if (dp) begin
                check($sformatf("il%0d.data", i), 64'(pop_data), 64'(expd));
                check($sformatf("il%0d.chan", i), 64'(pop_chan_r), 64'(pc));
            end
            check($sformatf("il%0d.occ", i), 64'({occ_of(1), occ_of(0)}),
                  64'({5'(q1.size()), 5'(q0.size())}));
            $display("interleave %0d: vld=%b data=%0h chan=%0d", i, pop_data_vld_r, pop_data, pop_chan_r);
        end
        while (q0.size() > 0) begin
            logic [31:0] e;
            e = q0.pop_front();
            do_pop(2'd0);
            check("ildrain0", 64'(pop_data), 64'(e));
            $display("drain ch0: data=%0h", pop_data);
        end
        while (q1.size() > 0) begin
            logic [31:0] e;
            e = q1.pop_front();
            do_pop(2'd1);
            check("ildrain1", 64'(pop_data), 64'(e));
            $display("drain ch1: data=%0h", pop_data);
        end
        idle(); step();
        check("il.empty", 64'(empty_r), 64'hF);
        check("il.err",   64'({ovf_err_r, unf_err_r}), 64'd0);

        // Flush ch1 with 5 entries and a same-cycle push
        for (int i = 0; i < 5; i++) do_push(2'd1, 32'h100 + 32'(i));
        check("pre_fl1.occ1", 64'(occ_of(1)), 64'd5);
        idle(); flush = 4'b0010; push = 1'b1; push_chan = 2'd1; push_data = 32'h99;
        step(); idle();
        check("fl1.occ1",  64'(occ_of(1)), 64'd0);
        check("fl1.empty", 64'(empty_r), 64'hF);
        check("fl1.err",   64'({ovf_err_r, unf_err_r}), 64'd0);
        $display("flush ch1: occ1=%0d empty=%b", occ_of(1), empty_r);

        // Mid-stream reset cancels in-flight pop and clears errors
        do_pop(2'd2);
        check("pre_rst.unf", 64'(unf_err_r), 64'h4);
        do_push(2'd0, 32'h42);
        idle(); pop = 1'b1; pop_chan = 2'd0; rst = 1'b0;
        step(); idle();
        check("mrst.vld",   64'(pop_data_vld_r), 64'd0);
        check("mrst.data",  64'(pop_data), 64'd0);
        check("mrst.chan",  64'(pop_chan_r), 64'd0);
        check("mrst.empty", 64'(empty_r), 64'hF);
        check("mrst.occ",   64'(occ_r), 64'd0);
        check("mrst.err",   64'({ovf_err_r, unf_err_r}), 64'd0);
        $display("mid-stream reset: vld=%b empty=%b occ=%0h", pop_data_vld_r, empty_r, occ_r);
        rst = 1'b1;
        step();
        do_push(2'd0, 32'h5A);
        do_pop(2'd0);
        check("post_rst.data", 64'(pop_data), 64'h5A);
        check("post_rst.vld",  64'(pop_data_vld_r), 64'd1);
        $display("post reset: data=%0h", pop_data);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mc_sync_queue.md
Name: mc_sync_queue

Overview:
- Single-clock, multi-channel FIFO. C independent logical queues, each N entries of W bits, share one push port and one pop port.
- Per-channel status comes from registered per-channel occupancy counters: empty, full, almost-full and occupancy.
- Adds flush, sticky overflow/underflow error capture and channel tagging on read data.
- Used by channelised datapaths upstream of arbiters in a single clock domain.

Parameters:
- W, 32, data width in bits.
- N, 16, entries per channel; power of two, >= 2.
- C, 4, number of channels; power of two, >= 2.
- AF_THRESH, 12, almost-full asserts when a channel's occupancy >= AF_THRESH; range 1..N.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  synchronous, active-low reset (rst == 0 resets on the clk edge).
- push  in  1  write request.
- push_chan  in  $clog2(C)  target channel of push.
- push_data  in  W  write data.
- pop  in  1  read request.
- pop_chan  in  $clog2(C)  source channel of pop.
- pop_data  out  W  read data, valid when pop_data_vld_r = 1.
- pop_data_vld_r  out  1  read data valid, one cycle after an accepted pop.
- pop_chan_r  out  $clog2(C)  channel of the current pop_data.
- flush  in  C  per-channel flush request (one-hot or multi-hot).
- clear_err  in  1  clears every error bit.
- empty_r  out  C  per-channel empty.
- full_r  out  C  per-channel full.
- almost_full_r  out  C  per-channel almost-full.
- occ_r  out  C*($clog2(N)+1)  per-channel occupancy, packed; channel k at [k*(L)+:L], L = $clog2(N)+1.
- ovf_err_r  out  C  sticky: push attempted to a full channel.
- unf_err_r  out  C  sticky: pop attempted from an empty channel.

Behaviour:
- Reset values: empty_r = all 1s; full_r, almost_full_r, occ_r, ovf_err_r, unf_err_r = 0; pop_data_vld_r = 0; pop_chan_r = 0; pop_data = 0. Storage contents are not reset.
- Per channel: read/write pointers of $clog2(N)+1 bits, with the MSB as the wrap bit. Storage address is {chan, ptr[$clog2(N)-1:0]}. Pointers wrap naturally modulo 2N.
- Full = wrap bits differ and address bits equal. Empty = pointers equal.
- All status outputs are registered and reflect the state after the current edge. No combinational path from inputs to outputs.
- Push is accepted iff push = 1, full_r[push_chan] = 0 and flush[push_chan] = 0. An accepted push writes storage and increments the channel's wptr and occ.
- Push to a full channel: dropped; ovf_err_r[push_chan] is set the next cycle.
- Pop is accepted iff pop = 1, empty_r[pop_chan] = 0 and flush[pop_chan] = 0. An accepted pop increments rptr and decrements occ.
- Pop latency: pop_data, pop_data_vld_r = 1 and pop_chan_r update on the edge after acceptance. pop_data holds its last value when pop_data_vld_r = 0.
- Pop from an empty channel: no data; pop_data_vld_r = 0; unf_err_r[pop_chan] is set.
- Push and pop to the same channel in one cycle:
  - Each is judged against current full_r/empty_r.
  - At full: the pop succeeds and the push is dropped with an overflow flagged.
  - At empty: the push succeeds and the pop underflows. No bypass; the data is readable from the next cycle.
  - Otherwise occ is unchanged and both pointers advance.
- Push and pop to different channels in one cycle are independent.
- Flush on channel k: on the next edge, rptr = wptr = 0, occ = 0, empty_r[k] = 1, full_r[k] = 0, almost_full_r[k] = 0. Flush dominates a same-cycle push or pop on k; those are silently dropped with no error flagged. Other channels are unaffected.
- almost_full_r[k] = (occ_k >= AF_THRESH); it is updated in the same cycle as occ.
- Error bits: clear_err has priority over a same-cycle set; the error is lost.
- Reset mid-operation: all pointers and counters return to their reset values; an in-flight pop_data_vld_r is cancelled.

Test Plan:
- Reset, then push 0xA0..0xA3 to ch1 and pop ch1 four times -> pop_data A0,A1,A2,A3 each one cycle after its pop; pop_chan_r = 1; occ ch1 4 -> 0; empty_r[1] = 1 at the end.
- Fill ch2 with 16 pushes, then a 17th push -> full_r[2] = 1 after the 16th; 17th dropped; ovf_err_r[2] = 1; occ ch2 = 16; almost_full_r[2] first set after the 12th push; other channels empty.
- Pop ch0 while empty -> pop_data_vld_r = 0, unf_err_r[0] = 1; then clear_err -> unf_err_r = 0.
- ch3 full, same-cycle push 0x55 and pop on ch3 -> pop returns the oldest entry; push dropped; ovf_err_r[3] = 1; occ stays 15. ch3 empty, same-cycle push and pop -> occ = 1, unf_err_r[3] = 1.
- Interleave ch0/ch1 pushes, pop ch0 while pushing ch1 for 40 cycles with pointer wrap -> per-channel order preserved; no cross-channel corruption.
- ch1 holding 5 entries; flush[1] with a same-cycle push to ch1 -> occ ch1 = 0, empty_r[1] = 1, no error; mid-stream rst = 0 -> all outputs at reset values next cycle.
